alu_ctrl_issue: RTL
===================

Name: alu_ctrl_issue

Overview:
- Producer end of the 6-bit ALU_Control interface consumed by the ALU.
- Decodes opcode/funct3/funct7 from the decode stage into ALU_Control, plus an illegal-instruction flag and a branch-class flag.
- Sits as the registered decode→execute boundary of the 7-stage pipeline.
- Provides a valid/ready handshake on both sides through a 2-entry skid buffer, so back-pressure from execute costs no throughput.

Parameters:
- TAG_WIDTH, 5, width of the opaque tag (e.g. rd index) carried alongside each decoded op unchanged.
- CNT_WIDTH, 32, width of the performance counters (only used when ALU_CTRL_PERF_EN is defined).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous; discards buffered ops.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  block can accept an op; registered.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- in_tag  in  TAG_WIDTH  passthrough tag.
- out_valid  out  1  ALU_Control valid toward execute.
- out_ready  in  1  execute accepts.
- ALU_Control  out  6  ALU operation code.
- out_illegal  out  1  op was not a recognised encoding.
- out_branch  out  1  op is conditional-branch class (ALU_Control[4:3]==2'b10).
- out_tag  out  TAG_WIDTH  tag of the current output op.

Behaviour:
- Handshake: a transfer occurs when valid && ready on a side.
  - out_valid, once high, holds and keeps all out_* stable until out_ready.
  - in_valid may rise regardless of in_ready.
- Latency: an accepted op appears on the outputs the next cycle when the output register is empty or draining.
- Storage is an output register plus one skid entry.
  - in_ready = !skid_full, registered.
  - If the output is stalled while an input is accepted, the op goes to skid; in_ready drops the following cycle.
  - When the output drains, skid moves to the output and in_ready returns high the next cycle.
  - Simultaneous in-accept and out-accept with skid empty: the new op goes directly to the output register; no bubble.
  - Order is strictly preserved.
- Decode table (opcode → ALU_Control):
  - R-type 0110011:
    - f3=000: f7=0000000 → ADD 000000; f7=0100000 → SUB 001000.
    - 001 → SLL 000001; 010 → SLT 000010; 011 → SLTU 000011; 100 → XOR 000100.
    - 101: f7=0000000 → SRL 000101; f7=0100000 → SRA 001101.
    - 110 → OR 000110; 111 → AND 000111.
    - Any other f7 → illegal.
  - I-type ALU 0010011: same mapping, except:
    - f3=000 is always ADD; funct7 is ignored, there is no SUBI.
    - f3=001 requires f7=0000000.
    - f3=101 uses f7 to pick SRLI/SRAI.
  - Branch 1100011, f3 → code:
    - 000 → 010000; 001 → 010001.
    - 100 → 010100; 101 → 010101.
    - 110 → 010110; 111 → 010111.
    - f3 010/011 → illegal.
  - JAL 1101111, and JALR 1100111 with f3=000 → 011111.
  - LOAD 0000011, STORE 0100011, LUI 0110111, AUIPC 0010111 → ADD 000000.
  - Any other opcode → illegal.
- Illegal ops: ALU_Control=000000, out_illegal=1, still passed through the handshake (never dropped).
- Flush:
  - Next edge clears the output register and skid: out_valid=0, in_ready=1.
  - An input presented in the flush cycle is discarded; in_ready is unaffected that cycle.
  - Flush has priority over all other updates.
- Reset values: out_valid=0, in_ready=1, ALU_Control=000000, out_illegal=0, out_branch=0, out_tag=0, counters=0.
  - Reset mid-transfer drops all buffered ops.

Optional Feature:
- Macro: ALU_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_issued [CNT_WIDTH-1:0] and perf_illegal [CNT_WIDTH-1:0].
  - perf_issued increments on each output-side transfer; perf_illegal increments on transfers with out_illegal=1.
  - Both wrap modulo 2^CNT_WIDTH and are not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode constants (OPC_RTYPE, OPC_ITYPE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC);
  - the 17 ALU_Control code constants (ALUC_ADD … ALUC_BGEU, ALUC_PASSA);
  - the illegal default.
- One sub-module, alu_ctrl_decode: purely combinational table lookup (opcode, funct3, funct7 → ALU_Control, illegal).
- The parent holds the skid buffer, handshake and counters.

Test Plan:
- Full sweep, out_ready=1: R-type f3=101 f7=0100000 → 001101 one cycle later; BLTU f3=110 → 010110 with out_branch=1; JALR → 011111.
- Illegal encodings: opcode 1111111 and branch f3=010 → ALU_Control=000000, out_illegal=1, out_valid=1.
- Back-pressure: stream 4 ops with out_ready=0 for 3 cycles → ops 1–2 held, in_ready=0 after the 2nd accept, no loss; release → ops emerge in order, one per cycle.
- Simultaneous accept/drain at full rate for 20 ops → zero bubbles, 20 transfers in 21 cycles.
- Flush with 2 ops buffered and in_valid=1 → next cycle out_valid=0, in_ready=1; none of the 3 ops ever appear.
- Async reset asserted mid-stall → outputs go to reset values immediately; with PERF_EN, perf_issued=0 and wraps correctly from all-ones to 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared constants for the decode->execute ALU_Control producer:
//   - major opcode values (instruction[6:0])
//   - funct7 qualifiers for the base and alternate encodings
//   - the 6-bit ALU_Control operation codes consumed by the ALU
//   - the code driven for unrecognised encodings
// Used by alu_ctrl_decode and alu_ctrl_issue. Optional build macro used by the
// issue stage: ALU_CTRL_PERF_EN (adds transfer/illegal performance counters).
package alu_ctrl_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 qualifiers
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU_Control codes
  localparam logic [5:0] ALUC_ADD   = 6'b000000;
  localparam logic [5:0] ALUC_SLL   = 6'b000001;
  localparam logic [5:0] ALUC_SLT   = 6'b000010;
  localparam logic [5:0] ALUC_SLTU  = 6'b000011;
  localparam logic [5:0] ALUC_XOR   = 6'b000100;
  localparam logic [5:0] ALUC_SRL   = 6'b000101;
  localparam logic [5:0] ALUC_OR    = 6'b000110;
  localparam logic [5:0] ALUC_AND   = 6'b000111;
  localparam logic [5:0] ALUC_SUB   = 6'b001000;
  localparam logic [5:0] ALUC_SRA   = 6'b001101;
  localparam logic [5:0] ALUC_BEQ   = 6'b010000;
  localparam logic [5:0] ALUC_BNE   = 6'b010001;
  localparam logic [5:0] ALUC_BLT   = 6'b010100;
  localparam logic [5:0] ALUC_BGE   = 6'b010101;
  localparam logic [5:0] ALUC_BLTU  = 6'b010110;
  localparam logic [5:0] ALUC_BGEU  = 6'b010111;
  localparam logic [5:0] ALUC_PASSA = 6'b011111;

  // Code carried by an op that failed to decode
  localparam logic [5:0] ALUC_ILLEGAL = 6'b000000;

  // One decoded op as it moves through the issue buffer
  typedef struct packed {
    logic [5:0] aluc;
    logic       illegal;
  } dec_t;

  // Base (funct7 = 0) arithmetic/logic op selected by funct3
  function automatic logic [5:0] alu_base(input logic [2:0] f3);
    logic [5:0] code;
    case (f3)
      3'b000:  code = ALUC_ADD;
      3'b001:  code = ALUC_SLL;
      3'b010:  code = ALUC_SLT;
      3'b011:  code = ALUC_SLTU;
      3'b100:  code = ALUC_XOR;
      3'b101:  code = ALUC_SRL;
      3'b110:  code = ALUC_OR;
      default: code = ALUC_AND;
    endcase
    return code;
  endfunction

  // Conditional-branch class is identified by bits [4:3] == 2'b10
  function automatic logic is_branch(input logic [5:0] aluc);
    return aluc[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
// Purely combinational table lookup from the instruction fields to the ALU
// operation code and an illegal-encoding flag.
// Ports:
//   opcode      in  7  instruction[6:0]
//   funct3      in  3  instruction[14:12]
//   funct7      in  7  instruction[31:25]
//   alu_control out 6  ALU operation code (ALUC_ILLEGAL when illegal)
//   illegal     out 1  encoding not recognised
module alu_ctrl_decode (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [5:0] alu_control,
  output logic       illegal
);
  import alu_ctrl_pkg::*;

  // Every path starts from "illegal" and only a recognised encoding clears it,
  // so any hole in the table falls back to the safe default.
  always_comb begin
    alu_control = ALUC_ILLEGAL;
    illegal     = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        if (funct7 == F7_BASE) begin
          alu_control = alu_base(funct3);
          illegal     = 1'b0;
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_control = ALUC_SUB;
          illegal     = 1'b0;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_control = ALUC_SRA;
          illegal     = 1'b0;
        end
      end
      OPC_ITYPE: begin
        // funct7 is immediate bits except for the shift forms
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) begin
              alu_control = ALUC_SLL;
              illegal     = 1'b0;
            end
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              alu_control = ALUC_SRL;
              illegal     = 1'b0;
            end else if (funct7 == F7_ALT) begin
              alu_control = ALUC_SRA;
              illegal     = 1'b0;
            end
          end
          default: begin
            alu_control = alu_base(funct3);
            illegal     = 1'b0;
          end
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000: begin alu_control = ALUC_BEQ;  illegal = 1'b0; end
          3'b001: begin alu_control = ALUC_BNE;  illegal = 1'b0; end
          3'b100: begin alu_control = ALUC_BLT;  illegal = 1'b0; end
          3'b101: begin alu_control = ALUC_BGE;  illegal = 1'b0; end
          3'b110: begin alu_control = ALUC_BLTU; illegal = 1'b0; end
          3'b111: begin alu_control = ALUC_BGEU; illegal = 1'b0; end
          default: ;
        endcase
      end
      OPC_JAL: begin
        alu_control = ALUC_PASSA;
        illegal     = 1'b0;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          alu_control = ALUC_PASSA;
          illegal     = 1'b0;
        end
      end
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC: begin
        // Address / upper-immediate forms only need an add
        alu_control = ALUC_ADD;
        illegal     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue
// Registered decode->execute boundary producing ALU_Control. Ops are decoded
// on entry and held in an output register backed by one skid entry, so a
// stall from execute never costs a cycle of throughput.
// Build macro: ALU_CTRL_PERF_EN adds perf_issued / perf_illegal counters.
// Ports:
//   clock, reset       clock; asynchronous active-high reset
//   flush              synchronous discard of every buffered op
//   in_valid/in_ready  upstream handshake (in_ready is a flop)
//   opcode/funct3/funct7, in_tag   instruction fields and passthrough tag
//   out_valid/out_ready downstream handshake
//   ALU_Control, out_illegal, out_branch, out_tag   current output op
//   perf_issued, perf_illegal      (ALU_CTRL_PERF_EN only) wrapping counters
module alu_ctrl_issue #(
  parameter int TAG_WIDTH = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           ALU_Control,
  output logic                 out_illegal,
  output logic                 out_branch,
  output logic [TAG_WIDTH-1:0] out_tag
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_issued,
  output logic [CNT_WIDTH-1:0] perf_illegal
`endif
);
  import alu_ctrl_pkg::*;

  typedef struct packed {
    dec_t                 dec;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t in_entry;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_full_q, skid_full_d;
  logic   in_ready_q;
  logic   in_fire;

  alu_ctrl_decode u_decode (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (in_entry.dec.aluc),
    .illegal     (in_entry.dec.illegal)
  );

  assign in_entry.tag = in_tag;

  // Next-state for the two-deep buffer. The output register refills whenever
  // it is empty or draining, preferring the older skid entry; a new op only
  // lands in skid while the output is stalled. in_ready is low whenever skid
  // is full, so a skid refill and an input accept never coincide.
  always_comb begin
    in_fire     = in_valid && in_ready_q && !flush;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (in_fire) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d      = in_entry;
      skid_full_d = 1'b1;
    end
  end

  // Buffer state; in_ready is registered from the next skid occupancy so it
  // drops the cycle after an op is parked and returns the cycle after skid
  // empties.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      in_ready_q  <= !skid_full_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign ALU_Control = out_q.dec.aluc;
  assign out_illegal = out_q.dec.illegal;
  assign out_branch  = is_branch(out_q.dec.aluc);
  assign out_tag     = out_q.tag;

`ifdef ALU_CTRL_PERF_EN
  // Counters follow output-side transfers only and deliberately survive flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issued  <= '0;
      perf_illegal <= '0;
    end else if (out_valid_q && out_ready) begin
      perf_issued <= perf_issued + CNT_WIDTH'(1);
      if (out_q.dec.illegal) begin
        perf_illegal <= perf_illegal + CNT_WIDTH'(1);
      end
    end
  end
`else
  // Keeps CNT_WIDTH referenced when the counters are compiled out.
  logic [CNT_WIDTH-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule
